// File: rtl/ib_serial_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ib_serial_packer                                                |
// | Packs NUM_CH bit-serial lanes into WORD_W-bit words for the IB SRAM      |
// | write port. Option macro: IB_PACK_LSB_FIRST_EN (LSB-first packing).      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ib_serial_packer #(
  parameter int NUM_CH = 8,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 29,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          num_words,
  input  logic                     bin_valid,
  input  logic [NUM_CH-1:0]        bin,
  output logic [NUM_CH*WORD_W-1:0] din,
  output logic [ADDR_W-1:0]        addr,
  output logic                     wea,
  output logic                     ena,
  output logic                     busy,
  output logic                     done
);

  localparam int                 c_BC_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int                 c_SH_W     = WORD_W - 1;
  localparam logic [c_BC_W-1:0]  c_BIT_LAST = c_BC_W'(WORD_W - 1);
  localparam logic [ADDR_W:0]    c_DEPTH    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  logic [c_BC_W-1:0]           r_bit_cnt;
  logic [ADDR_W:0]             r_word_cnt;
  logic [ADDR_W-1:0]           r_base;
  logic [ADDR_W:0]             r_num;
  logic [NUM_CH*c_SH_W-1:0]    r_shreg;
  logic [NUM_CH*WORD_W-1:0]    r_din;
  logic [ADDR_W-1:0]           r_addr;
  logic                        r_wea;
  logic                        r_busy;
  logic                        r_done;

  logic                        w_accept;
  logic                        w_last_word;
  logic [ADDR_W:0]             w_num_eff;
  logic [NUM_CH*WORD_W-1:0]    w_full;
  logic [NUM_CH*c_SH_W-1:0]    w_sh_next;

  assign w_accept    = (r_state == S_FILL) && bin_valid && !start;
  assign w_last_word = (r_word_cnt == (r_num - 1'b1));
  assign w_num_eff   = ((num_words == '0) || (num_words > c_DEPTH)) ? c_DEPTH : num_words;

  // w_full is the lane word as it would look with the current bit appended;
  // the shift register keeps only the WORD_W-1 bits still needed.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
`ifdef IB_PACK_LSB_FIRST_EN
    assign w_full[c*WORD_W +: WORD_W]    = {bin[c], r_shreg[c*c_SH_W +: c_SH_W]};
    assign w_sh_next[c*c_SH_W +: c_SH_W] = w_full[c*WORD_W+1 +: c_SH_W];
`else
    assign w_full[c*WORD_W +: WORD_W]    = {r_shreg[c*c_SH_W +: c_SH_W], bin[c]};
    assign w_sh_next[c*c_SH_W +: c_SH_W] = w_full[c*WORD_W +: c_SH_W];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_base     <= '0;
      r_num      <= '0;
      r_shreg    <= '0;
      r_din      <= '0;
      r_addr     <= '0;
      r_wea      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wea <= 1'b0;
      if (start) begin
        // Restart from any state; a word completing this cycle is dropped.
        r_state    <= S_FILL;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_shreg    <= '0;
        r_base     <= base_addr;
        r_num      <= w_num_eff;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
      end else if (w_accept) begin
        r_shreg <= w_sh_next;
        if (r_bit_cnt == c_BIT_LAST) begin
          r_bit_cnt  <= '0;
          r_din      <= w_full;
          r_wea      <= 1'b1;
          r_addr     <= r_base + r_word_cnt[ADDR_W-1:0];
          r_word_cnt <= r_word_cnt + 1'b1;
          if (w_last_word) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign din  = r_din;
  assign addr = r_addr;
  assign wea  = r_wea;
  assign ena  = r_wea;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ib_serial_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_ib_serial_packer                                             |
// | Directed self-checking bench for ib_serial_packer.                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ib_serial_packer;
  localparam int NUM_CH = 8;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [ADDR_W-1:0]        base_addr = '0;
  logic [ADDR_W:0]          num_words = '0;
  logic                     bin_valid = 1'b0;
  logic [NUM_CH-1:0]        bin = '0;
  logic [NUM_CH*WORD_W-1:0] din;
  logic [ADDR_W-1:0]        addr;
  logic                     wea, ena, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int wea_cnt = 0;
  logic [WORD_W-1:0] cur_words [NUM_CH];

  ib_serial_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .bin_valid(bin_valid), .bin(bin), .din(din),
    .addr(addr), .wea(wea), .ena(ena), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (wea === 1'b1) wea_cnt++;

  function automatic logic [NUM_CH-1:0] lane_bits(input int k);
    logic [NUM_CH-1:0] b;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef IB_PACK_LSB_FIRST_EN
      b[c] = cur_words[c][k];
`else
      b[c] = cur_words[c][WORD_W-1-k];
`endif
    end
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input logic [NUM_CH-1:0] b);
    bin_valid = v;
    bin       = b;
    step();
  endtask

  // Gapped mode puts an invalid cycle carrying inverted data before each bit.
  task automatic send_word(input bit gapped);
    for (int k = 0; k < WORD_W; k++) begin
      if (gapped) drive_bit(1'b0, ~lane_bits(k));
      drive_bit(1'b1, lane_bits(k));
    end
  endtask

  // Start cycle carries bin_valid=1 with all-ones data that must be ignored.
  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    start = 1'b1; base_addr = b; num_words = n; bin_valid = 1'b1; bin = '1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    vectors++; if ({din, addr, wea, ena, busy, done} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got din=%h addr=%0d wea=%b busy=%b done=%b, expected all zero", din, addr, wea, busy, done);
    end
    rst_n = 1'b1;
    bin_valid = 1'b1; bin = '1;
    repeat (40) step();
    vectors++; if (wea_cnt !== 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_ignores_bits: got wea_cnt=%0d busy=%b, expected 0 and 0", wea_cnt, busy);
    end
  endtask

  task automatic test_full_frame();
    int w0;
    for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'hA5A5_0000 | c;
    w0 = wea_cnt;
    pulse_start(5'd0, 6'd29);
    vectors++; if (busy !== 1'b1 || done !== 1'b0 || wea !== 1'b0) begin
      miscompares++; $display("FAIL t1_after_start: got busy=%b done=%b wea=%b, expected 1 0 0", busy, done, wea);
    end
    for (int w = 0; w < 29; w++) begin
      send_word(1'b0);
      vectors++; if (wea !== 1'b1 || ena !== 1'b1 || addr !== 5'(w)) begin
        miscompares++; $display("FAIL t1_write w=%0d: got wea=%b ena=%b addr=%0d, expected 1 1 %0d", w, wea, ena, addr, w);
      end
      vectors++; if (done !== (w == 28) || busy !== (w != 28)) begin
        miscompares++; $display("FAIL t1_flags w=%0d: got done=%b busy=%b, expected %b %b", w, done, busy, w == 28, w != 28);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        vectors++; if (din[c*WORD_W +: WORD_W] !== cur_words[c]) begin
          miscompares++; $display("FAIL t1_din w=%0d lane=%0d: got %h, expected %h", w, c, din[c*WORD_W +: WORD_W], cur_words[c]);
        end
      end
    end
    repeat (40) step();
    vectors++; if (wea_cnt - w0 !== 29) begin
      miscompares++; $display("FAIL t1_wea_count: got %0d, expected 29", wea_cnt - w0);
    end
    vectors++; if (done !== 1'b1 || addr !== 5'd28 || din[WORD_W-1:0] !== 32'hA5A5_0000) begin
      miscompares++; $display("FAIL t1_hold_in_done: got done=%b addr=%0d lane0=%h, expected 1 28 a5a50000", done, addr, din[WORD_W-1:0]);
    end
  endtask

  task automatic test_wrap();
    int w0;
    logic [ADDR_W-1:0] ea;
    w0 = wea_cnt;
    pulse_start(5'd30, 6'd4);
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'hC3C3_0000 | (w << 8) | c;
      ea = 5'(30 + w);
      send_word(1'b0);
      vectors++; if (wea !== 1'b1 || addr !== ea) begin
        miscompares++; $display("FAIL t2_addr w=%0d: got wea=%b addr=%0d, expected 1 %0d", w, wea, addr, ea);
      end
      vectors++; if (done !== (w == 3)) begin
        miscompares++; $display("FAIL t2_done w=%0d: got %b, expected %b", w, done, w == 3);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        vectors++; if (din[c*WORD_W +: WORD_W] !== cur_words[c]) begin
          miscompares++; $display("FAIL t2_din w=%0d lane=%0d: got %h, expected %h", w, c, din[c*WORD_W +: WORD_W], cur_words[c]);
        end
      end
    end
    step();
    vectors++; if (wea_cnt - w0 !== 4) begin
      miscompares++; $display("FAIL t2_wea_count: got %0d, expected 4", wea_cnt - w0);
    end
  endtask

  task automatic test_gapped();
    int w0;
    for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'hA5A5_0000 | c;
    w0 = wea_cnt;
    pulse_start(5'd3, 6'd2);
    for (int w = 0; w < 2; w++) begin
      send_word(1'b1);
      vectors++; if (wea !== 1'b1 || addr !== 5'(3 + w) || done !== (w == 1)) begin
        miscompares++; $display("FAIL t3_write w=%0d: got wea=%b addr=%0d done=%b, expected 1 %0d %b", w, wea, addr, done, 3 + w, w == 1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        vectors++; if (din[c*WORD_W +: WORD_W] !== cur_words[c]) begin
          miscompares++; $display("FAIL t3_din w=%0d lane=%0d: got %h, expected %h", w, c, din[c*WORD_W +: WORD_W], cur_words[c]);
        end
      end
    end
    step();
    vectors++; if (wea_cnt - w0 !== 2) begin
      miscompares++; $display("FAIL t3_wea_count: got %0d, expected 2", wea_cnt - w0);
    end
  endtask

  task automatic test_restart();
    int w0, c0;
    for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'h1357_9BDF ^ c;
    w0 = wea_cnt;
    pulse_start(5'd20, 6'd29);
    send_word(1'b0);
    for (int k = 0; k < 13; k++) drive_bit(1'b1, lane_bits(k));
    c0 = wea_cnt;
    vectors++; if (c0 - w0 !== 1) begin
      miscompares++; $display("FAIL t4_first_frame_writes: got %0d, expected 1", c0 - w0);
    end
    pulse_start(5'd10, 6'd1);
    vectors++; if (busy !== 1'b1 || done !== 1'b0 || wea !== 1'b0) begin
      miscompares++; $display("FAIL t4_restart_flags: got busy=%b done=%b wea=%b, expected 1 0 0", busy, done, wea);
    end
    for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'h0F1E_2D3C + c;
    send_word(1'b0);
    vectors++; if (wea !== 1'b1 || addr !== 5'd10 || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL t4_write: got wea=%b addr=%0d done=%b busy=%b, expected 1 10 1 0", wea, addr, done, busy);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      vectors++; if (din[c*WORD_W +: WORD_W] !== cur_words[c]) begin
        miscompares++; $display("FAIL t4_din lane=%0d: got %h, expected %h", c, din[c*WORD_W +: WORD_W], cur_words[c]);
      end
    end
    step();
    vectors++; if (wea_cnt - c0 !== 1) begin
      miscompares++; $display("FAIL t4_wea_count: got %0d, expected 1", wea_cnt - c0);
    end
  endtask

  task automatic test_start_collision();
    int c0;
    for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'h6996_0000 | c;
    pulse_start(5'd0, 6'd2);
    for (int k = 0; k < WORD_W - 1; k++) drive_bit(1'b1, lane_bits(k));
    c0 = wea_cnt;
    start = 1'b1; base_addr = 5'd4; num_words = 6'd1; bin_valid = 1'b1; bin = lane_bits(WORD_W - 1);
    step();
    start = 1'b0;
    vectors++; if (wea !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL t4b_collision_dropped: got wea=%b busy=%b, expected 0 1", wea, busy);
    end
    for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'hDEAD_BE00 | c;
    send_word(1'b0);
    vectors++; if (wea !== 1'b1 || addr !== 5'd4 || din[3*WORD_W +: WORD_W] !== 32'hDEAD_BE03) begin
      miscompares++; $display("FAIL t4b_after_collision: got wea=%b addr=%0d lane3=%h, expected 1 4 deadbe03", wea, addr, din[3*WORD_W +: WORD_W]);
    end
    step();
    vectors++; if (wea_cnt - c0 !== 1) begin
      miscompares++; $display("FAIL t4b_wea_count: got %0d, expected 1", wea_cnt - c0);
    end
  endtask

  task automatic test_num_clamp();
    logic [ADDR_W:0] nums [2];
    nums[0] = 6'd0;
    nums[1] = 6'd40;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'h0000_7700 | c;
      pulse_start(5'd0, nums[i]);
      for (int w = 0; w < 28; w++) send_word(1'b0);
      vectors++; if (done !== 1'b0 || busy !== 1'b1) begin
        miscompares++; $display("FAIL clamp_28 num=%0d: got done=%b busy=%b, expected 0 1", nums[i], done, busy);
      end
      send_word(1'b0);
      vectors++; if (done !== 1'b1 || addr !== 5'd28 || wea !== 1'b1) begin
        miscompares++; $display("FAIL clamp_29 num=%0d: got done=%b addr=%0d wea=%b, expected 1 28 1", nums[i], done, addr, wea);
      end
    end
  endtask

  task automatic test_async_reset();
    int c0;
    for (int c = 0; c < NUM_CH; c++) cur_words[c] = 32'hF00D_0000 | c;
    pulse_start(5'd7, 6'd3);
    send_word(1'b0);
    vectors++; if (wea !== 1'b1 || addr !== 5'd7) begin
      miscompares++; $display("FAIL t5_pre_write: got wea=%b addr=%0d, expected 1 7", wea, addr);
    end
    for (int k = 0; k < 10; k++) drive_bit(1'b1, lane_bits(k));
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({din, addr, wea, ena, busy, done} !== '0) begin
      miscompares++; $display("FAIL t5_async_clear: got din=%h addr=%0d wea=%b busy=%b done=%b, expected all zero", din, addr, wea, busy, done);
    end
    step();
    rst_n = 1'b1;
    c0 = wea_cnt;
    bin_valid = 1'b1;
    repeat (40) step();
    vectors++; if (wea_cnt !== c0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL t5_no_write_after_reset: got writes=%0d busy=%b, expected 0 0", wea_cnt - c0, busy);
    end
    pulse_start(5'd2, 6'd1);
    send_word(1'b0);
    vectors++; if (wea !== 1'b1 || addr !== 5'd2 || din[WORD_W +: WORD_W] !== 32'hF00D_0001) begin
      miscompares++; $display("FAIL t5_post_reset_write: got wea=%b addr=%0d lane1=%h, expected 1 2 f00d0001", wea, addr, din[WORD_W +: WORD_W]);
    end
  endtask

  task automatic test_bit_order();
    logic [WORD_W-1:0] exp_w;
`ifdef IB_PACK_LSB_FIRST_EN
    exp_w = 32'h0000_0001;
`else
    exp_w = 32'h8000_0000;
`endif
    pulse_start(5'd0, 6'd1);
    drive_bit(1'b1, '1);
    for (int k = 1; k < WORD_W; k++) drive_bit(1'b1, '0);
    vectors++; if (wea !== 1'b1) begin
      miscompares++; $display("FAIL t6_wea: got %b, expected 1", wea);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      vectors++; if (din[c*WORD_W +: WORD_W] !== exp_w) begin
        miscompares++; $display("FAIL t6_order lane=%0d: got %h, expected %h", c, din[c*WORD_W +: WORD_W], exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_wrap();
    test_gapped();
    test_restart();
    test_start_collision();
    test_num_clamp();
    test_async_reset();
    test_bit_order();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
